mac_seq_ctrl: RTL and testbench

Parametrised sequencer for the matrix processor's MAC datapath. It generalises the single-row element sequencer into a multi-row controller. For each row it clears the accumulator, then steps through `cycles_in` elements with load/multiply/accumulate enables and a thermometer `memsel`, then pulses `next`. After the last row it pulses `done`. It adds stall, abort and an optional overlapped (pipelined) MAC schedule.

---
 rtl/mac_seq_ctrl_if.sv | 33 +++
 rtl/mac_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Handshake bundle between the job issuer (master) and the MAC sequencer (slave).
interface mac_seq_ctrl_if #(
  parameter int SIZE = 16,
  parameter int ROWS = 16
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam int RW = $clog2(ROWS) + 1;

  logic          start;
  logic [CW-1:0] cycles_in;
  logic [RW-1:0] rows_in;
  logic          stall;
  logic          abort;
  logic          load_en;
  logic          mult_en;
  logic          acc_en;
  logic          acc_clr;
  logic [SIZE-1:0] memsel;
  logic [RW-1:0] row_idx;
  logic          next;
  logic          done;
  logic          busy;

  modport master (
    output start, cycles_in, rows_in, stall, abort,
    input  load_en, mult_en, acc_en, acc_clr, memsel, row_idx, next, done, busy
  );

  modport slave (
    input  start, cycles_in, rows_in, stall, abort,
    output load_en, mult_en, acc_en, acc_clr, memsel, row_idx, next, done, busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Multi-row MAC sequencer: clear / element schedule / next per row, done per job.
// Define MACSEQ_PIPE_EN for the overlapped load/mult/acc schedule (P = N+4).
module mac_seq_ctrl #(
  parameter int SIZE = 16,
  parameter int ROWS = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mac_seq_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam int RW = $clog2(ROWS) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_ROWEND = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   n_q, n_d, n_clamp;
  logic [RW-1:0]   r_q, r_d, r_clamp;
  logic [RW-1:0]   row_q, row_d;
  logic [SIZE-1:0] memsel_q, memsel_d;
  logic            load_q, load_d, mult_q, mult_d, acc_q, acc_d;
  logic            clr_q, clr_d, next_q, next_d, done_q, done_d, busy_q, busy_d;
  logic            step_s;  // an element step is issued after this edge
`ifdef MACSEQ_PIPE_EN
  logic [CW:0]     cyc_q, cyc_d;
`else
  logic [CW-1:0]   elem_q, elem_d;
  logic [1:0]      phase_q, phase_d;
`endif

  assign n_clamp = (bus.cycles_in > CW'(SIZE)) ? CW'(SIZE) : bus.cycles_in;
  assign r_clamp = (bus.rows_in > RW'(ROWS)) ? RW'(ROWS) : bus.rows_in;

  // state register and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      r_q      <= '0;
      row_q    <= '0;
      memsel_q <= '0;
      load_q   <= 1'b0;
      mult_q   <= 1'b0;
      acc_q    <= 1'b0;
      clr_q    <= 1'b0;
      next_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MACSEQ_PIPE_EN
      cyc_q    <= '0;
`else
      elem_q   <= '0;
      phase_q  <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      r_q      <= r_d;
      row_q    <= row_d;
      memsel_q <= memsel_d;
      load_q   <= load_d;
      mult_q   <= mult_d;
      acc_q    <= acc_d;
      clr_q    <= clr_d;
      next_q   <= next_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MACSEQ_PIPE_EN
      cyc_q    <= cyc_d;
`else
      elem_q   <= elem_d;
      phase_q  <= phase_d;
`endif
    end
  end

  // next-state and step counters; a stall in RUN holds every counter
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    row_d   = row_q;
    step_s  = 1'b0;
`ifdef MACSEQ_PIPE_EN
    cyc_d   = cyc_q;
`else
    elem_d  = elem_q;
    phase_d = phase_q;
`endif
    if (bus.abort) begin
      state_d = S_IDLE;
      row_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            n_d     = n_clamp;
            r_d     = r_clamp;
            row_d   = '0;
            state_d = (r_clamp == '0) ? S_DONE : S_CLR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLR: begin
`ifdef MACSEQ_PIPE_EN
          cyc_d   = '0;
`else
          elem_d  = '0;
          phase_d = 2'd0;
`endif
          if (n_q == '0) begin
            state_d = S_ROWEND;
          end else begin
            state_d = S_RUN;
            step_s  = 1'b1;
          end
        end
        S_RUN: begin
          if (bus.stall) begin
            step_s = 1'b0;
`ifdef MACSEQ_PIPE_EN
          end else if (cyc_q == ({1'b0, n_q} + (CW+1)'(1))) begin
            state_d = S_ROWEND;
          end else begin
            cyc_d  = cyc_q + (CW+1)'(1);
            step_s = 1'b1;
          end
`else
          end else if ((phase_q == 2'd2) && (elem_q == (n_q - CW'(1)))) begin
            state_d = S_ROWEND;
          end else if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            elem_d  = elem_q + CW'(1);
            step_s  = 1'b1;
          end else begin
            phase_d = phase_q + 2'd1;
            step_s  = 1'b1;
          end
`endif
        end
        S_ROWEND: begin
          if (row_q == (r_q - RW'(1))) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_CLR;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // output values for the cycle after this edge, derived from the next state
  always_comb begin
    clr_d  = (state_d == S_CLR);
    next_d = (state_d == S_ROWEND);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    load_d = 1'b0;
    mult_d = 1'b0;
    acc_d  = 1'b0;
    if (step_s) begin
`ifdef MACSEQ_PIPE_EN
      load_d = (cyc_d < {1'b0, n_q});
      mult_d = (cyc_d != '0) && (cyc_d <= {1'b0, n_q});
      acc_d  = (cyc_d >= (CW+1)'(2));
`else
      case (phase_d)
        2'd0:    load_d = 1'b1;
        2'd1:    mult_d = 1'b1;
        2'd2:    acc_d  = 1'b1;
        default: load_d = 1'b0;
      endcase
`endif
    end else begin
      load_d = 1'b0;
    end
    if (bus.abort || (state_d == S_CLR)) begin
      memsel_d = '0;
    end else if (load_d) begin
      memsel_d = {memsel_q[SIZE-2:0], 1'b1};
    end else begin
      memsel_d = memsel_q;
    end
  end

  assign bus.load_en = load_q;
  assign bus.mult_en = mult_q;
  assign bus.acc_en  = acc_q;
  assign bus.acc_clr = clr_q;
  assign bus.memsel  = memsel_q;
  assign bus.row_idx = row_q;
  assign bus.next    = next_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: a job-level model queues every expected output event.
module tb_mac_seq_ctrl;
  localparam int SIZE = 16;
  localparam int ROWS = 16;
  localparam int CW   = $clog2(SIZE) + 1;
  localparam int RW   = $clog2(ROWS) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.SIZE(SIZE), .ROWS(ROWS)) bus ();
  mac_seq_ctrl #(.SIZE(SIZE), .ROWS(ROWS)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  // flags: {acc_clr, load_en, mult_en, acc_en, next, done}
  typedef struct {
    int              cyc;
    logic [5:0]      flags;
    logic [SIZE-1:0] ms;
    logic [RW-1:0]   row;
  } ev_t;

  ev_t             exp_q[$];
  ev_t             mon_e;
  logic [5:0]      mon_f;
  int              cnt = 0;
  int              n_checks = 0;
  int              n_err = 0;
  bit              stall_plan[4096];
  logic [SIZE-1:0] m_memsel = '0;
  int              m_row = 0;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic void chk(string name, longint act, longint expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cnt, act, expv);
    end
  endfunction

  function automatic logic [SIZE-1:0] ones(int k);
    logic [SIZE-1:0] m = '0;
    for (int i = 0; i < SIZE; i++) if (i < k) m[i] = 1'b1;
    return m;
  endfunction

  function automatic void push(int c, logic [5:0] f, logic [SIZE-1:0] ms, int row);
    ev_t e;
    e.cyc = c; e.flags = f; e.ms = ms; e.row = RW'(row);
    exp_q.push_back(e);
  endfunction

  // enables {load, mult, acc} and memsel of step s in a row of nn elements
  function automatic logic [2:0] step_en(int s, int nn);
`ifdef MACSEQ_PIPE_EN
    return {s < nn, (s >= 1) && (s <= nn), s >= 2};
`else
    return (s % 3 == 0) ? 3'b100 : ((s % 3 == 1) ? 3'b010 : 3'b001);
`endif
  endfunction

  function automatic logic [SIZE-1:0] step_ms(int s, int nn);
`ifdef MACSEQ_PIPE_EN
    return ones((s < nn) ? s + 1 : nn);
`else
    return ones(s / 3 + 1);
`endif
  endfunction

  // queue every event of a job accepted at edge e0; returns done offset from e0
  function automatic int build(int e0, int n, int r);
    int nn = (n > SIZE) ? SIZE : n;
    int rr = (r > ROWS) ? ROWS : r;
    int rel = 0;
    int nsteps;
`ifdef MACSEQ_PIPE_EN
    nsteps = (nn == 0) ? 0 : nn + 2;
`else
    nsteps = 3 * nn;
`endif
    if (rr == 0) begin
      push(e0, 6'b000001, m_memsel, 0);
      m_row = 0;
      return 0;
    end
    for (int row = 0; row < rr; row++) begin
      push(e0 + rel, 6'b100000, '0, row);
      rel++;
      for (int s = 0; s < nsteps; s++) begin
        if (s > 0) while (stall_plan[rel] && rel < 4000) rel++;
        push(e0 + rel, {1'b0, step_en(s, nn), 2'b00}, step_ms(s, nn), row);
        rel++;
      end
      if (nsteps > 0) while (stall_plan[rel] && rel < 4000) rel++;
      push(e0 + rel, 6'b000010, ones(nn), row);
      rel++;
    end
    push(e0 + rel, 6'b000001, ones(nn), rr - 1);
    m_memsel = ones(nn);
    m_row    = rr - 1;
    return rel;
  endfunction

  // monitor: every cycle with an event output high consumes one expected event
  always @(negedge clk) begin
    mon_f = {bus.acc_clr, bus.load_en, bus.mult_en, bus.acc_en, bus.next, bus.done};
    if (mon_f != 6'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_event at cycle %0d: flags %b, none expected", cnt, mon_f);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_cycle", longint'(cnt), longint'(mon_e.cyc));
        chk("ev_flags", longint'(mon_f), longint'(mon_e.flags));
        chk("ev_memsel", longint'(bus.memsel), longint'(mon_e.ms));
        chk("ev_row", longint'(bus.row_idx), longint'(mon_e.row));
      end
    end
  end

  // cut_rel: -1 none, -2 random abort, >=0 abort/reset at that edge offset
  // stall_mode: 0 none, 1 random, 2 preset plan
  task automatic run_job(int n, int r, int cut_rel, bit cut_is_reset, int stall_mode);
    int e0, done_rel, last, cut, lim;
    if (stall_mode != 2)
      for (int i = 0; i < 4096; i++)
        stall_plan[i] = (stall_mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
    e0       = cnt + 1;
    done_rel = build(e0, n, r);
    cut      = cut_rel;
    if (cut == -2) cut = (done_rel >= 1) ? $urandom_range(1, done_rel) : -1;
    last = done_rel + 1;
    if (cut >= 0) begin
      lim = e0 + cut;
      while (exp_q.size() > 0 && exp_q[$].cyc >= lim) void'(exp_q.pop_back());
      last = cut;
    end
    bus.cycles_in = CW'(n);
    bus.rows_in   = RW'(r);
    for (int rel = 0; rel <= last; rel++) begin
      bus.start = (rel == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      bus.stall = stall_plan[rel];
      bus.abort = (cut == rel) && !cut_is_reset;
      reset     = (cut == rel) && cut_is_reset;
      @(posedge clk); #1;
      if (cut < 0 && rel == done_rel) chk("busy_at_done", longint'(bus.busy), 64'd1);
    end
    bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0; reset = 1'b0;
    if (cut >= 0) begin
      chk("cut_outputs", longint'({bus.acc_clr, bus.load_en, bus.mult_en, bus.acc_en,
                                   bus.next, bus.done, bus.busy}), 64'd0);
      m_memsel = '0;
      m_row    = 0;
    end else begin
      chk("busy_after_done", longint'(bus.busy), 64'd0);
    end
    chk("memsel_hold", longint'(bus.memsel), longint'(m_memsel));
    chk("row_hold", longint'(bus.row_idx), longint'(m_row));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.cycles_in = '0; bus.rows_in = '0;
    bus.stall = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", longint'({bus.acc_clr, bus.load_en, bus.mult_en, bus.acc_en,
                                   bus.next, bus.done, bus.busy}), 64'd0);
    chk("reset_memsel", longint'(bus.memsel), 64'd0);
    chk("reset_row", longint'(bus.row_idx), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(4, 2, 5, 1'b1, 0);      // reset mid-RUN
    run_job(3, 1, -1, 1'b0, 0);
    run_job(2, 3, -1, 1'b0, 0);
    for (int i = 0; i < 4096; i++) stall_plan[i] = 1'b0;
    stall_plan[6] = 1'b1;
    stall_plan[7] = 1'b1;
    run_job(3, 1, -1, 1'b0, 2);     // stall during MULT of element 1
    run_job(2, 2, 11, 1'b0, 0);     // abort in RUN of row 1
    run_job(0, 2, -1, 1'b0, 0);
    run_job(3, 0, -1, 1'b0, 0);
    run_job(4, 1, -1, 1'b0, 0);
    run_job(20, 2, -1, 1'b0, 1);    // N clamps to SIZE
    run_job(1, 20, -1, 1'b0, 1);    // R clamps to ROWS
    for (int j = 0; j < 40; j++)
      run_job($urandom_range(0, SIZE + 2), $urandom_range(0, 4),
              ($urandom_range(0, 5) == 0) ? -2 : -1, 1'b0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", longint'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
